// File: rtl/ysyx_24100005_lsu.sv
// ysyx_24100005_lsu -- multi-cycle RV32 load/store unit.
//
// Takes one load/store request at a time from the execute stage and drives a
// word-aligned memory port. Stores get byte-lane placement and a write mask.
// Loads get lane extraction and sign/zero extension. Misaligned accesses and
// illegal funct3 values are answered directly, without touching memory. A
// response timeout stops a stalled memory from hanging the core.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   req_*                    request from execute (valid/ready, wen, funct3, addr, wdata)
//   mem_req_*                memory request (valid/ready, wen, word addr, lane data, mask)
//   mem_resp_valid/rdata     one-cycle memory response pulse and raw read word
//   resp_*                   result to consumer (valid/ready, extended rdata, err code)
//   dbg_state                current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer that raises valid holds it and its payload stable
// until that edge. Ready may depend on state but never on the same-cycle
// valid of the other side. mem_resp_valid has no ready; it is a one-cycle pulse.
module ysyx_24100005_lsu #(
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [1:0]           state;
  logic                 wen_q;
  logic [2:0]           funct3_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [1:0]           err_q;
  logic [TIMEOUT_W-1:0] cnt;
  logic [TIMEOUT_W-1:0] cnt_inc;

  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign cnt_inc = cnt + CNT_ONE;

  // Request classification from the live inputs, used in IDLE only.
  // funct3[1:0] encodes the size for both loads and stores (00 B, 01 H, 10 W).
  always_comb begin
    req_illegal = 1'b0;
    if (req_wen) begin
      req_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                      req_funct3 == 3'b010);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        default:                                req_illegal = 1'b1;
      endcase
    end
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Store lane placement from the latched request. Loads write nothing.
  always_comb begin
    st_wdata = '0;
    st_wmask = '0;
    if (wen_q) begin
      case (funct3_q)
        3'b000: begin
          st_wdata = {4{wdata_q[7:0]}};
          st_wmask = 4'b0001 << addr_q[1:0];
        end
        3'b001: begin
          st_wdata = {2{wdata_q[15:0]}};
          st_wmask = 4'b0011 << addr_q[1:0];
        end
        3'b010: begin
          st_wdata = wdata_q;
          st_wmask = 4'b1111;
        end
        default: begin
          st_wdata = '0;
          st_wmask = '0;
        end
      endcase
    end
  end

  // Load lane extraction from the raw word, captured when the response arrives.
  always_comb begin
    ld_byte = mem_resp_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_resp_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_resp_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wen_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wen_q    <= req_wen;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            if (req_illegal) begin
              err_q <= ERR_ILL;
              state <= S_RESP;
            end else if (req_misaligned) begin
              err_q <= ERR_ALIGN;
              state <= S_RESP;
            end else begin
              err_q <= ERR_OK;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          // A response in the same cycle as the timeout wins.
          if (mem_resp_valid) begin
            rdata_q <= wen_q ? 32'd0 : ld_data;
            err_q   <= ERR_OK;
            state   <= S_RESP;
          end else if (cnt_inc == CNT_MAX) begin
            rdata_q <= '0;
            err_q   <= ERR_TMO;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state == S_IDLE);
  assign mem_req_valid = (state == S_ISSUE);
  assign mem_req_wen   = wen_q && (state == S_ISSUE);
  assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_req_wdata = st_wdata;
  assign mem_req_wmask = st_wmask;
  assign resp_valid    = (state == S_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Testbench for ysyx_24100005_lsu: table of request/response vectors plus
// hand-written timeout, late-response and mid-transaction reset sequences.
module tb_ysyx_24100005_lsu;

  localparam int ADDR_W    = 32;
  localparam int TIMEOUT_W = 3;
  localparam int NVEC      = 16;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [1:0]  dbg_state;

  ysyx_24100005_lsu #(.ADDR_W(ADDR_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;      // word returned by the memory model
    logic        issue;      // a memory request is expected
    logic        respond;    // memory model answers (0 = force timeout)
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          rdy_dly;    // cycles mem_req_ready is held low
    int          hold;       // cycles resp_ready is held low
  } vec_t;

  vec_t        vecs[NVEC];
  logic [33:0] exp_q[$];     // {err, rdata}
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic issue,
                              input logic respond, input logic [31:0] ewd,
                              input logic [3:0] ewm, input logic [31:0] erd,
                              input logic [1:0] eerr, input int rdy_dly,
                              input int hold);
    vec_t v;
    v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.issue = issue; v.respond = respond; v.exp_wdata = ewd; v.exp_wmask = ewm;
    v.exp_rdata = erd; v.exp_err = eerr; v.rdy_dly = rdy_dly; v.hold = hold;
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
  endtask

  // Driver + memory model + response checker for one request.
  task automatic do_txn(input vec_t v, input int idx);
    int          cyc, hs, rdy_cnt, exp_lat;
    logic        hs_prev, ok, stable;
    logic [31:0] held_rd;
    logic [1:0]  held_err;
    logic [33:0] exp;
    string       n;
    n = $sformatf("v%0d", idx);
    exp_lat = !v.issue ? 0 :
              (v.respond ? 2 + v.rdy_dly : 1 + v.rdy_dly + (2**TIMEOUT_W - 1));
    @(negedge clk);
    check({n, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = v.wen; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(negedge clk);
    idle_inputs();
    cyc = 0; hs = 0; rdy_cnt = 0; hs_prev = 1'b0; ok = 1'b1;
    while (!resp_valid && cyc < 64) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      if (hs_prev && v.respond) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = v.rdata;
      end
      hs_prev = 1'b0;
      if (mem_req_valid) begin
        if (!v.issue || mem_req_addr !== {v.addr[31:2], 2'b00} ||
            mem_req_wen !== v.wen || mem_req_wdata !== v.exp_wdata ||
            mem_req_wmask !== v.exp_wmask)
          ok = 1'b0;
        if (rdy_cnt >= v.rdy_dly) begin
          mem_req_ready = 1'b1;
          hs_prev = 1'b1;
          hs++;
        end
        rdy_cnt++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    check({n, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({n, "_latency"}, cyc, exp_lat);
    check({n, "_mem_handshakes"}, hs, v.issue ? 1 : 0);
    check({n, "_mem_fields"}, {31'd0, ok}, 32'd1);
    check({n, "_req_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
    held_rd = resp_rdata; held_err = resp_err; stable = 1'b1;
    for (int k = 0; k < v.hold; k++) begin
      resp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      if (!resp_valid || resp_rdata !== held_rd || resp_err !== held_err) stable = 1'b0;
    end
    check({n, "_resp_stable"}, {31'd0, stable}, 32'd1);
    resp_ready = 1'b1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    check({n, "_rdata"}, resp_rdata, exp[31:0]);
    check({n, "_err"}, {30'd0, resp_err}, {30'd0, exp[33:32]});
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    check({n, "_resp_done"}, {31'd0, resp_valid}, 32'd0);
    check({n, "_back_idle"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string n);
    check({n, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({n, "_mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    check({n, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({n, "_resp_err"}, {30'd0, resp_err}, 32'd0);
    check({n, "_resp_rdata"}, resp_rdata, 32'd0);
    check({n, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet;
    idle_inputs();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    resp_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_wmask", {28'd0, mem_req_wmask}, 32'd0);
    check("reset_mem_addr", mem_req_addr, 32'd0);
    check("reset_mem_wen", {31'd0, mem_req_wen}, 32'd0);
    rst = 1'b1;

    //               wen f3      addr          wdata         rdata         iss rsp exp_wdata     wmask    exp_rdata     err   rdy hold
    vecs[0]  = mk(0, 3'b000, 32'h8000_0003, 32'h0,        32'h80AA_BBCC, 1, 1, 32'h0,        4'b0000, 32'hFFFF_FF80, 2'b00, 0, 0);
    vecs[1]  = mk(0, 3'b101, 32'h8000_0002, 32'h0,        32'h9234_5678, 1, 1, 32'h0,        4'b0000, 32'h0000_9234, 2'b00, 0, 1);
    vecs[2]  = mk(0, 3'b001, 32'h8000_0002, 32'h0,        32'h9234_5678, 1, 1, 32'h0,        4'b0000, 32'hFFFF_9234, 2'b00, 0, 0);
    vecs[3]  = mk(1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'h0,        1, 1, 32'hABAB_ABAB, 4'b0010, 32'h0,        2'b00, 5, 0);
    vecs[4]  = mk(0, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        2'b01, 0, 4);
    vecs[5]  = mk(0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        2'b11, 0, 4);
    vecs[6]  = mk(0, 3'b100, 32'h8000_0001, 32'h0,        32'h1234_8056, 1, 1, 32'h0,        4'b0000, 32'h0000_0080, 2'b00, 2, 0);
    vecs[7]  = mk(0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 1, 1, 32'h0,        4'b0000, 32'hDEAD_BEEF, 2'b00, 1, 2);
    vecs[8]  = mk(1, 3'b001, 32'h8000_0002, 32'h0000_CAFE, 32'hFFFF_FFFF, 1, 1, 32'hCAFE_CAFE, 4'b1100, 32'h0,        2'b00, 0, 0);
    vecs[9]  = mk(1, 3'b010, 32'h8000_0008, 32'h1122_3344, 32'h0,        1, 1, 32'h1122_3344, 4'b1111, 32'h0,        2'b00, 0, 0);
    vecs[10] = mk(1, 3'b001, 32'h8000_0003, 32'h0000_1111, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        2'b01, 0, 0);
    vecs[11] = mk(1, 3'b101, 32'h8000_0001, 32'h0000_2222, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        2'b11, 0, 0);
    vecs[12] = mk(0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 1, 1, 32'h0,        4'b0000, 32'h0000_007F, 2'b00, 0, 0);
    vecs[13] = mk(0, 3'b001, 32'hFFFF_FFFE, 32'h0,        32'h8001_0000, 1, 1, 32'h0,        4'b0000, 32'hFFFF_8001, 2'b00, 0, 0);
    vecs[14] = mk(0, 3'b010, 32'h8000_0000, 32'h0,        32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        2'b10, 1, 0);
    vecs[15] = mk(0, 3'b010, 32'h8000_0000, 32'h0,        32'hCAFE_F00D, 1, 1, 32'h0,        4'b0000, 32'hCAFE_F00D, 2'b00, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      do_txn(vecs[i], i);
      if (vecs[i].issue && !vecs[i].respond) begin
        // Late response after a timeout must be ignored.
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_AAAA;
        @(posedge clk); @(negedge clk);
        mem_resp_valid = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
          if (resp_valid || !req_ready) quiet = 1'b0;
          @(posedge clk); @(negedge clk);
        end
        check($sformatf("v%0d_late_resp_ignored", i), {31'd0, quiet}, 32'd1);
      end
    end

    // Reset while ISSUE is presenting a request: mem_req_valid drops at once.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h8000_0040; req_wdata = 32'h0BAD_0BAD;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    check("issue_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_in_issue");
    @(negedge clk);
    rst = 1'b1;

    // Reset while in WAIT: outputs return to reset values before the next edge.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0020;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    mem_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_req_ready = 1'b0;
    check("wait_state", {30'd0, dbg_state}, 32'd2);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_in_wait");
    @(negedge clk);
    rst = 1'b1;
    // The aborted load's response shows up late; no result may be emitted.
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
    @(posedge clk); @(negedge clk);
    mem_resp_valid = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      if (resp_valid || !req_ready) quiet = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    check("no_stale_resp", {31'd0, quiet}, 32'd1);
    do_txn(mk(1, 3'b010, 32'h8000_0010, 32'hA5A5_0F0F, 32'h0, 1, 1,
              32'hA5A5_0F0F, 4'b1111, 32'h0, 2'b00, 0, 0), 99);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
